// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM among NUM_REQ masters, one access in flight.
// Optional macro ARB_CPU_PRIORITY_EN: requester 0 wins every arbitration where it is requesting.
module ram_arbiter #(
    parameter int unsigned NUM_REQ     = 3,
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned RAM_LATENCY = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ-1:0]              req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wr_data,
    output logic [NUM_REQ-1:0]              ack,
    output logic [DATA_WIDTH-1:0]           rd_data,
    output logic [NUM_REQ-1:0]              grant,
    output logic [ADDR_WIDTH-1:0]           ram_addr,
    output logic [DATA_WIDTH-1:0]           ram_wr_data,
    output logic                            ram_wren,
    input  logic [DATA_WIDTH-1:0]           ram_rd_data,
    output logic                            busy
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_ACK
    } state_t;

    state_t                  state_q;
    logic [IDX_W-1:0]        last_q;
    logic [IDX_W-1:0]        owner_q;
    logic [CNT_W-1:0]        wait_cnt_q;
    logic [NUM_REQ-1:0]      ack_q;
    logic [NUM_REQ-1:0]      grant_q;
    logic [DATA_WIDTH-1:0]   rd_data_q;
    logic [ADDR_WIDTH-1:0]   ram_addr_q;
    logic [DATA_WIDTH-1:0]   ram_wr_data_q;
    logic                    ram_wren_q;
    logic                    busy_q;

    logic [NUM_REQ-1:0]      req_eff_c;
    logic [IDX_W-1:0]        win_idx_c;
    logic                    win_found_c;
    logic [ADDR_WIDTH-1:0]   win_addr_c;
    logic [DATA_WIDTH-1:0]   win_data_c;
    logic                    win_we_c;
    int unsigned             cand;

    // Winner search: first requesting index after last_served, wrapping.
    always_comb begin
        req_eff_c   = req;
        win_idx_c   = '0;
        win_found_c = 1'b0;
        cand        = 0;
`ifdef ARB_CPU_PRIORITY_EN
        // Masking down to bit 0 makes the search land on the CPU wherever it starts.
        if (req[0]) begin
            req_eff_c = NUM_REQ'(1);
        end
`endif
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = (32'(last_q) + k) % NUM_REQ;
            if (!win_found_c && req_eff_c[IDX_W'(cand)]) begin
                win_found_c = 1'b1;
                win_idx_c   = IDX_W'(cand);
            end
        end
    end

    // Payload mux for the selected requester.
    always_comb begin
        win_addr_c = '0;
        win_data_c = '0;
        win_we_c   = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_idx_c == IDX_W'(i)) begin
                win_addr_c = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                win_data_c = req_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
                win_we_c   = req_we[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            last_q        <= IDX_W'(NUM_REQ - 1);
            owner_q       <= '0;
            wait_cnt_q    <= '0;
            ack_q         <= '0;
            grant_q       <= '0;
            rd_data_q     <= '0;
            ram_addr_q    <= '0;
            ram_wr_data_q <= '0;
            ram_wren_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (win_found_c) begin
                        owner_q       <= win_idx_c;
                        grant_q       <= NUM_REQ'(1) << win_idx_c;
                        ram_addr_q    <= win_addr_c;
                        ram_wr_data_q <= win_data_c;
                        ram_wren_q    <= win_we_c;
                        busy_q        <= 1'b1;
                        state_q       <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    ram_wren_q <= 1'b0;
                    if (ram_wren_q) begin
                        ack_q   <= grant_q;
                        state_q <= S_ACK;
                    end else begin
                        wait_cnt_q <= CNT_W'(RAM_LATENCY - 1);
                        state_q    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt_q == '0) begin
                        rd_data_q <= ram_rd_data;
                        ack_q     <= grant_q;
                        state_q   <= S_ACK;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - CNT_W'(1);
                    end
                end
                S_ACK: begin
                    ack_q   <= '0;
                    grant_q <= '0;
                    last_q  <= owner_q;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ack         = ack_q;
    assign rd_data     = rd_data_q;
    assign grant       = grant_q;
    assign ram_addr    = ram_addr_q;
    assign ram_wr_data = ram_wr_data_q;
    assign ram_wren    = ram_wren_q;
    assign busy        = busy_q;

endmodule
